d_cache_line: RTL and testbench

- Parametrised successor to the single-word data cache.
- Direct-mapped, write-through data cache with multi-word lines and sequential word-by-word refill from memory.
- Adds a parametrised uncached region, full per-byte write merge, global invalidate, and hit/miss performance counters.
- Sits between the CPU data port (p_*) and the memory/AXI bridge (m_*).

---
 rtl/d_cache_pkg.sv | 19 +
 rtl/cache_data_ram.sv | 20 ++
 rtl/d_cache_line.sv | 157 +++++++++++++++
 tb/tb_d_cache_line.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_pkg.sv
// Shared types and constants for the direct-mapped, write-through line cache.
package d_cache_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    UNC    = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic int tag_w(input int a_width, input int c_index, input int l_offset);
    return a_width - c_index - l_offset - 2;
  endfunction

  function automatic int line_words(input int l_offset);
    return 1 << l_offset;
  endfunction
endpackage

// File: rtl/cache_data_ram.sv
// Cache data store: async read port, sync byte-enabled write port, no reset.
module cache_data_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/d_cache_line.sv
// Direct-mapped write-through data cache, multi-word lines refilled word by word,
// uncached window, global invalidate and saturating hit/miss counters.
module d_cache_line
  import d_cache_pkg::*;
#(
  parameter int          A_WIDTH   = 32,
  parameter int          C_INDEX   = 6,
  parameter int          L_OFFSET  = 2,
  parameter logic [15:0] UNC_HI    = 16'hffff,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [A_WIDTH-1:0]   p_a,
  input  logic [31:0]          p_dout,
  output logic [31:0]          p_din,
  input  logic                 p_strobe,
  input  logic                 p_rw,
  input  logic [3:0]           p_wen,
  input  logic [1:0]           p_size,
  output logic                 p_ready,
  input  logic                 inval,
  output logic [A_WIDTH-1:0]   m_a,
  input  logic [31:0]          m_dout,
  output logic [31:0]          m_din,
  output logic                 m_strobe,
  output logic                 m_rw,
  output logic [3:0]           m_wen,
  output logic [1:0]           m_size,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);
  localparam int T     = tag_w(A_WIDTH, C_INDEX, L_OFFSET);
  localparam int LINES = 2**C_INDEX;
  localparam int RAW   = C_INDEX + L_OFFSET;

  state_t state, state_nx;
  logic [T-1:0]        tags [LINES];
  logic [LINES-1:0]    valid;
  logic [L_OFFSET-1:0] cnt;
  logic                abort;

  logic [T-1:0]        tag_in;
  logic [C_INDEX-1:0]  idx;
  logic [L_OFFSET-1:0] word;
  logic                uncached, hit, refill_done;
  logic                hit_ev, miss_ev;
  logic [RAW-1:0]      ram_waddr;
  logic [31:0]         ram_wdata, ram_rdata;
  logic [3:0]          ram_we;

  assign tag_in      = p_a[A_WIDTH-1 -: T];
  assign idx         = p_a[C_INDEX+L_OFFSET+1 : L_OFFSET+2];
  assign word        = p_a[L_OFFSET+1 : 2];
  assign uncached    = (p_a[31:16] == UNC_HI);
  assign hit         = valid[idx] & (tags[idx] == tag_in) & ~uncached;
  assign refill_done = (state == REFILL) & m_ready & (&cnt);

  cache_data_ram #(.AW(RAW)) u_ram (
    .clk   (clk),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .wbe   (ram_we),
    .raddr ({idx, word}),
    .rdata (ram_rdata)
  );

  assign p_din = (state == UNC) ? m_dout : ram_rdata;

  always_comb begin
    state_nx  = state;
    m_strobe  = 1'b0;
    m_rw      = 1'b0;
    m_a       = p_a;
    m_din     = p_dout;
    m_wen     = 4'hf;
    m_size    = SIZE_WORD;
    p_ready   = 1'b0;
    ram_we    = 4'h0;
    ram_waddr = {idx, word};
    ram_wdata = p_dout;
    hit_ev    = 1'b0;
    miss_ev   = 1'b0;
    case (state)
      IDLE: if (p_strobe) begin
        if (p_rw)          state_nx = WRITE;
        else if (uncached) state_nx = UNC;
        else if (hit) begin
          p_ready = 1'b1;
          hit_ev  = 1'b1;
        end else begin
          state_nx = REFILL;
          miss_ev  = 1'b1;
        end
      end
      REFILL: begin
        m_strobe  = 1'b1;
        m_a       = {tag_in, idx, cnt, 2'b00};
        ram_waddr = {idx, cnt};
        ram_wdata = m_dout;
        if (m_ready) begin
          ram_we = 4'hf;
          if (&cnt) state_nx = IDLE;
        end
      end
      WRITE: begin
        m_strobe = 1'b1;
        m_rw     = 1'b1;
        m_wen    = p_wen;
        m_size   = p_size;
        if (m_ready) begin
          p_ready  = 1'b1;
          state_nx = IDLE;
          // write-through merge only on a hit; misses never allocate
          if (hit) ram_we = p_wen;
        end
      end
      UNC: begin
        m_strobe = 1'b1;
        m_wen    = p_wen;
        m_size   = p_size;
        if (m_ready) begin
          p_ready  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      valid    <= '0;
      cnt      <= '0;
      abort    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nx;
      if (miss_ev) cnt <= '0;
      else if (state == REFILL && m_ready) cnt <= cnt + L_OFFSET'(1);
      // an invalidate during refill must keep the in-flight line from going valid
      if (refill_done)                   abort <= 1'b0;
      else if (inval && state == REFILL) abort <= 1'b1;
      if (inval)            valid      <= '0;
      else if (refill_done) valid[idx] <= ~abort;
      if (hit_ev && !(&hit_cnt))   hit_cnt  <= hit_cnt + CNT_WIDTH'(1);
      if (miss_ev && !(&miss_cnt)) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (refill_done) tags[idx] <= tag_in;
  end
endmodule

// File: tb/tb_d_cache_line.sv
// Randomized scoreboard bench for d_cache_line against a line-level cache model.
module tb_d_cache_line;
  logic        clk = 1'b0, clrn = 1'b0;
  logic [31:0] p_a = '0, p_dout = '0, p_din;
  logic        p_strobe = 1'b0, p_rw = 1'b0, p_ready;
  logic [3:0]  p_wen = 4'hf;
  logic [1:0]  p_size = 2'b10;
  logic        inval, inval_a = 1'b0, inval_b = 1'b0;
  logic [31:0] m_a, m_dout = '0, m_din;
  logic        m_strobe, m_rw, m_ready = 1'b0;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;
  logic [31:0] hit_cnt, miss_cnt;

  assign inval = inval_a | inval_b;
  always #5 clk = ~clk;

  d_cache_line dut (
    .clk(clk), .clrn(clrn), .p_a(p_a), .p_dout(p_dout), .p_din(p_din),
    .p_strobe(p_strobe), .p_rw(p_rw), .p_wen(p_wen), .p_size(p_size),
    .p_ready(p_ready), .inval(inval), .m_a(m_a), .m_dout(m_dout), .m_din(m_din),
    .m_strobe(m_strobe), .m_rw(m_rw), .m_wen(m_wen), .m_size(m_size),
    .m_ready(m_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct { bit rd; bit hit; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] a; logic rw; logic [3:0] wen; logic [1:0] size; logic [31:0] din; } mop_t;
  exp_t exp_q[$];
  mop_t mexp_q[$];

  logic [31:0] mem [bit [31:0]];
  bit          mv [64];
  logic [21:0] mt [64];
  logic [31:0] md [64][4];
  int          m_hits = 0, m_miss = 0;
  int          n_chk = 0, n_fail = 0;
  int          done_cnt = 0;
  bit          slave_en = 1'b1, inv_w2 = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h9e37, a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  // memory slave: random latency, checks each handshake against the expected op stream
  initial begin
    int   wl;
    mop_t e;
    wl = 0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      inval_b = 1'b0;
      if (slave_en && clrn && m_strobe) begin
        if (inv_w2 && !m_rw && m_a[3:2] == 2'd2) begin
          inval_b = 1'b1;
          inv_w2  = 1'b0;
        end else if (wl > 0) wl--;
        else begin
          m_ready = 1'b1;
          if (!m_rw) m_dout = mem_rd(m_a);
          else mem[m_a] = merge(mem_rd(m_a), m_din, m_wen);
          if (mexp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL mem_req: unexpected request at %h rw %b", m_a, m_rw);
          end else begin
            e = mexp_q.pop_front();
            chk("mem_req", {m_a, 3'b0, m_rw, m_wen, 2'b0, m_size, (m_rw ? m_din : 32'h0)},
                           {e.a, 3'b0, e.rw, e.wen, 2'b0, e.size, e.din});
          end
          wl = $urandom_range(0, 2);
        end
      end
    end
  end

  // CPU-side monitor: pops expected response whenever p_ready completes a request
  initial begin
    int   cyc;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clk); #1;
      if (clrn && p_strobe) begin
        if (p_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL p_ready: completion with nothing outstanding");
          end else begin
            e = exp_q.pop_front();
            if (e.rd)  chk("p_din", p_din, e.data);
            if (e.hit) chk("hit_latency", cyc, 0);
          end
          cyc = 0;
          done_cnt++;
        end else cyc++;
      end else cyc = 0;
    end
  end

  task automatic do_req(input logic [31:0] a, input logic rw, input logic [3:0] wen,
                        input logic [31:0] dout, input logic [1:0] size, input bit inv = 1'b0);
    logic [21:0] tg;
    logic [5:0]  idx;
    logic [1:0]  w;
    bit          unc, hitm;
    int          d0, t, reps;
    tg   = a[31:10]; idx = a[9:4]; w = a[3:2];
    unc  = (a[31:16] == 16'hffff);
    hitm = mv[idx] && (mt[idx] == tg) && !unc;
    if (rw) begin
      mexp_q.push_back('{a, 1'b1, wen, size, dout});
      if (hitm) md[idx][w] = merge(md[idx][w], dout, wen);
      exp_q.push_back('{1'b0, 1'b0, 32'h0});
    end else if (unc) begin
      mexp_q.push_back('{a, 1'b0, wen, size, 32'h0});
      exp_q.push_back('{1'b1, 1'b0, mem_rd(a)});
    end else begin
      if (!hitm) begin
        reps = inv ? 2 : 1;
        if (inv) for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        for (int r = 0; r < reps; r++)
          for (int k = 0; k < 4; k++)
            mexp_q.push_back('{{a[31:4], 4'h0} + 32'(4*k), 1'b0, 4'hf, 2'b10, 32'h0});
        for (int k = 0; k < 4; k++) md[idx][k] = mem_rd({a[31:4], 4'h0} + 32'(4*k));
        mv[idx] = 1'b1; mt[idx] = tg;
        m_miss += reps;
      end
      m_hits++;
      exp_q.push_back('{1'b1, hitm, md[idx][w]});
    end
    @(posedge clk); #1;
    inv_w2 = inv;
    p_a = a; p_rw = rw; p_wen = wen; p_dout = dout; p_size = size; p_strobe = 1'b1;
    d0 = done_cnt; t = 0;
    while (done_cnt == d0 && t < 200) begin @(posedge clk); t++; end
    #1;
    p_strobe = 1'b0;
    if (done_cnt == d0) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: no p_ready for address %h", a);
      finish_now();
    end
    chk("mem_ops_left", mexp_q.size(), 0);
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic pulse_inval();
    @(posedge clk); #1 inval_a = 1'b1;
    @(posedge clk); #1 inval_a = 1'b0;
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          t;
    mem[32'h40] = 32'h11; mem[32'h44] = 32'h22; mem[32'h48] = 32'h33; mem[32'h4c] = 32'h44;
    repeat (3) @(posedge clk);
    #3 clrn = 1'b1;
    @(negedge clk);
    chk("rst_m_strobe", m_strobe, 0);
    chk("rst_p_ready", p_ready, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);

    do_req(32'h40, 1'b0, 4'hf, 32'h0, 2'b10);
    do_req(32'h48, 1'b0, 4'hf, 32'h0, 2'b10);
    do_req(32'h44, 1'b1, 4'b0011, 32'haabb_ccdd, 2'b10);
    do_req(32'h44, 1'b0, 4'hf, 32'h0, 2'b10);
    do_req(32'h1000, 1'b1, 4'hf, 32'h1234_5678, 2'b10);
    do_req(32'h1000, 1'b0, 4'hf, 32'h0, 2'b10);
    do_req(32'hffff_0010, 1'b0, 4'hf, 32'h0, 2'b01);
    do_req(32'hffff_0010, 1'b0, 4'hf, 32'h0, 2'b00);
    do_req(32'h44, 1'b0, 4'hf, 32'h0, 2'b10);
    do_req(32'h2000, 1'b0, 4'hf, 32'h0, 2'b10, 1'b1);
    do_req(32'h2008, 1'b0, 4'hf, 32'h0, 2'b10);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 15) a = {16'hffff, 8'h0, 6'($urandom), 2'b00};
      else a = {21'h0, 1'($urandom), 4'h0, 2'($urandom), 2'($urandom), 2'b00};
      if ($urandom_range(0, 99) < 5) pulse_inval();
      do_req(a, 1'($urandom_range(0, 2) == 0), 4'($urandom_range(1, 15)), $urandom, 2'($urandom));
    end

    // asynchronous reset in the middle of a refill
    @(posedge clk); #1;
    slave_en = 1'b0;
    p_a = 32'h7000; p_rw = 1'b0; p_strobe = 1'b1;
    t = 0;
    while (!m_strobe && t < 20) begin @(negedge clk); t++; end
    chk("refill_started", m_strobe, 1);
    #2 clrn = 1'b0;
    #1;
    chk("rst_mid_m_strobe", m_strobe, 0);
    chk("rst_mid_p_ready", p_ready, 0);
    chk("rst_mid_hit_cnt", hit_cnt, 0);
    chk("rst_mid_miss_cnt", miss_cnt, 0);
    p_strobe = 1'b0;
    finish_now();
  end
endmodule
